// File: rtl/frame_receiver_pkg.sv
// Shared definitions for the LED-chain serial frame receiver.
package frame_receiver_pkg;
  localparam int unsigned CH_PER_BOARD = 32;
  localparam int unsigned DEF_BPC      = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_FULL,
    ST_ERR
  } state_e;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);
  logic q1_q, q2_q, q3_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q1_q <= 1'b0;
      q2_q <= 1'b0;
      q3_q <= 1'b0;
    end else begin
      q1_q <= i_d;
      q2_q <= q1_q;
      q3_q <= q2_q;
    end
  end

  assign o_rise = q2_q & ~q3_q;
endmodule

// File: rtl/frame_receiver.sv
// Receives host frames over SCLK/SDI/LAT and writes channel words into the target framebuffer.
module frame_receiver
  import frame_receiver_pkg::*;
#(
  parameter int unsigned c_ledboards = 30,
  parameter int unsigned c_bpc       = DEF_BPC,
  parameter int unsigned c_max_time  = 480,
  localparam int unsigned CH = c_ledboards * CH_PER_BOARD,
  localparam int unsigned AW = $clog2(CH),
  localparam int unsigned TW = $clog2(c_max_time),
  localparam int unsigned BW = $clog2(c_bpc)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_sclk,
  input  logic          i_sdi,
  input  logic          i_lat,
  output logic          o_wen,
  output logic [AW-1:0] o_waddr,
  output logic [c_bpc-1:0] o_wdata,
  output logic [TW-1:0] o_time,
  output logic          o_commit,
  output logic          o_err
);
  localparam logic [AW:0]   CH_M1   = (AW+1)'(CH - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(c_bpc - 1);

  logic sclk_rise, lat_rise;
  logic sdi_q1, sdi_q2;

  sync_edge u_sync_sclk (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk), .o_rise(sclk_rise));
  sync_edge u_sync_lat  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_lat),  .o_rise(lat_rise));

  // Data runs through the same two stages so it lines up with the synchronised clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sdi_q1 <= 1'b0;
      sdi_q2 <= 1'b0;
    end else begin
      sdi_q1 <= i_sdi;
      sdi_q2 <= sdi_q1;
    end
  end

  state_e             state_q, state_d;
  logic [c_bpc-2:0]   shift_q, shift_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [AW:0]        word_cnt_q, word_cnt_d;
  logic [TW-1:0]      hdr_q, hdr_d;
  logic               wen_q, wen_d, commit_q, commit_d, err_q, err_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [c_bpc-1:0]   wdata_q, wdata_d;
  logic [TW-1:0]      time_q, time_d;
  logic [c_bpc-1:0]   word;
  logic               last_bit;

  assign word     = {shift_q, sdi_q2};
  assign last_bit = (bit_cnt_q == BIT_MAX);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    hdr_d      = hdr_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    time_d     = time_q;
    wen_d      = 1'b0;
    commit_d   = 1'b0;
    err_d      = 1'b0;

    if (lat_rise) begin
      // A coincident SCLK edge is dropped: the latch closes the frame first.
      if (state_q == ST_FULL && bit_cnt_q == '0) begin
        commit_d = 1'b1;
        time_d   = hdr_q;
      end else if (state_q != ST_IDLE) begin
        err_d = 1'b1;
      end
      state_d    = ST_IDLE;
      shift_d    = '0;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (sclk_rise) begin
      case (state_q)
        ST_IDLE, ST_HDR, ST_DATA: begin
          shift_d   = word[c_bpc-2:0];
          bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
          if (state_q == ST_IDLE) state_d = ST_HDR;
          if (last_bit && state_q == ST_HDR) begin
            hdr_d      = (32'(word) > c_max_time) ? TW'(c_max_time) : TW'(word);
            state_d    = ST_DATA;
            word_cnt_d = '0;
          end else if (last_bit && state_q == ST_DATA) begin
            // First data word belongs to the far end of the daisy chain.
            wen_d      = 1'b1;
            wdata_d    = word;
            waddr_d    = AW'(CH_M1 - word_cnt_q);
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == CH_M1) state_d = ST_FULL;
          end
        end
        ST_FULL: state_d = ST_ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      hdr_q      <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      time_q     <= '0;
      commit_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      hdr_q      <= hdr_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      time_q     <= time_d;
      commit_q   <= commit_d;
      err_q      <= err_d;
    end
  end

  assign o_wen    = wen_q;
  assign o_waddr  = waddr_q;
  assign o_wdata  = wdata_q;
  assign o_time   = time_q;
  assign o_commit = commit_q;
  assign o_err    = err_q;
endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver with two boards (64 channels).
`timescale 1ns/1ps
module tb_frame_receiver;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_sclk = 1'b0, i_sdi = 1'b0, i_lat = 1'b0;
  logic        o_wen, o_commit, o_err;
  logic [5:0]  o_waddr;
  logic [11:0] o_wdata;
  logic [8:0]  o_time;

  int checks = 0, failures = 0;
  int wen_cnt = 0, commit_cnt = 0, err_cnt = 0, dbl_wen = 0;
  logic        prev_wen = 1'b0;
  logic [11:0] mem [64];
  logic [5:0]  addr_log [4096];
  logic [11:0] data_log [4096];

  frame_receiver #(.c_ledboards(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_sdi(i_sdi), .i_lat(i_lat),
    .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_time(o_time),
    .o_commit(o_commit), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_wen) begin
      if (prev_wen) dbl_wen++;
      mem[o_waddr] = o_wdata;
      if (wen_cnt < 4096) begin
        addr_log[wen_cnt] = o_waddr;
        data_log[wen_cnt] = o_wdata;
      end
      wen_cnt++;
    end
    prev_wen = o_wen;
    if (o_commit) commit_cnt++;
    if (o_err) err_cnt++;
  end

  task automatic send_bit(input logic b);
    @(posedge i_clk); #1 i_sdi = b;
    @(posedge i_clk); #1 i_sclk = 1'b1;
    @(posedge i_clk); @(posedge i_clk); #1 i_sclk = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] w, input int nbits);
    for (int i = 11; i > 11 - nbits; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [11:0] hdr, input logic [11:0] base, input int nwords);
    send_word(hdr, 12);
    for (int k = 0; k < nwords; k++) send_word(base + 12'(k), 12);
  endtask

  task automatic pulse_lat(output int lat_cyc);
    lat_cyc = -1;
    @(posedge i_clk); #1 i_lat = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge i_clk); #1;
      if (lat_cyc < 0 && (o_commit || o_err)) lat_cyc = c;
    end
    i_lat = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({o_wen, o_waddr, o_wdata, o_time, o_commit, o_err} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {o_wen, o_waddr, o_wdata, o_time, o_commit, o_err});
    end
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
  endtask

  task automatic test_full_frame();
    int w0, c0, e0, lc, bad;
    w0 = wen_cnt; c0 = commit_cnt; e0 = err_cnt;
    send_frame(12'd100, 12'h100, 64);
    pulse_lat(lc);
    checks++; if (wen_cnt - w0 !== 64) begin failures++; $display("FAIL full_wen_count got=%0d exp=64", wen_cnt - w0); end
    checks++; if (addr_log[w0] !== 6'd63) begin failures++; $display("FAIL full_first_addr got=%0d exp=63", addr_log[w0]); end
    bad = 0;
    for (int k = 0; k < 64; k++) if (mem[63-k] !== 12'h100 + 12'(k)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL full_mem_content bad_words=%0d exp=0", bad); end
    checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL full_commit got=%0d exp=1", commit_cnt - c0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL full_err got=%0d exp=0", err_cnt - e0); end
    checks++; if (o_time !== 9'd100) begin failures++; $display("FAIL full_time got=%0d exp=100", o_time); end
    checks++; if (lc !== 3) begin failures++; $display("FAIL commit_latency got=%0d exp=3", lc); end
  endtask

  task automatic test_clamp();
    int c0, lc;
    c0 = commit_cnt;
    send_frame(12'hFFF, 12'h000, 64);
    pulse_lat(lc);
    checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL clamp_commit got=%0d exp=1", commit_cnt - c0); end
    checks++; if (o_time !== 9'd480) begin failures++; $display("FAIL clamp_time got=%0d exp=480", o_time); end
  endtask

  task automatic test_short();
    int w0, c0, e0, lc;
    w0 = wen_cnt; c0 = commit_cnt; e0 = err_cnt;
    send_frame(12'd50, 12'h300, 10);
    pulse_lat(lc);
    checks++; if (wen_cnt - w0 !== 10) begin failures++; $display("FAIL short_wen_count got=%0d exp=10", wen_cnt - w0); end
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL short_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (commit_cnt - c0 !== 0) begin failures++; $display("FAIL short_commit got=%0d exp=0", commit_cnt - c0); end
    checks++; if (o_time !== 9'd480) begin failures++; $display("FAIL short_time_kept got=%0d exp=480", o_time); end
    checks++; if (lc !== 3) begin failures++; $display("FAIL err_latency got=%0d exp=3", lc); end
  endtask

  task automatic test_overflow();
    int w0, c0, e0, lc;
    w0 = wen_cnt; c0 = commit_cnt; e0 = err_cnt;
    send_frame(12'd7, 12'h400, 64);
    send_word(12'hFFF, 5);
    pulse_lat(lc);
    checks++; if (wen_cnt - w0 !== 64) begin failures++; $display("FAIL ovf_wen_count got=%0d exp=64", wen_cnt - w0); end
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ovf_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (commit_cnt - c0 !== 0) begin failures++; $display("FAIL ovf_commit got=%0d exp=0", commit_cnt - c0); end
    w0 = wen_cnt; c0 = commit_cnt; e0 = err_cnt;
    send_frame(12'd9, 12'h500, 63);
    send_word(12'hABC, 11);
    pulse_lat(lc);
    checks++; if (wen_cnt - w0 !== 63) begin failures++; $display("FAIL partial_wen_count got=%0d exp=63", wen_cnt - w0); end
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL partial_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (commit_cnt - c0 !== 0) begin failures++; $display("FAIL partial_commit got=%0d exp=0", commit_cnt - c0); end
    checks++; if (o_time !== 9'd480) begin failures++; $display("FAIL partial_time_kept got=%0d exp=480", o_time); end
  endtask

  task automatic test_lat_sclk_collide();
    int c0, e0, lc;
    c0 = commit_cnt; e0 = err_cnt;
    send_frame(12'd200, 12'h600, 64);
    @(posedge i_clk); #1 i_sdi = 1'b1;
    @(posedge i_clk); #1 i_lat = 1'b1; i_sclk = 1'b1;
    repeat (6) @(posedge i_clk);
    #1 i_sclk = 1'b0; i_lat = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL collide_commit got=%0d exp=1", commit_cnt - c0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL collide_err got=%0d exp=0", err_cnt - e0); end
    checks++; if (o_time !== 9'd200) begin failures++; $display("FAIL collide_time got=%0d exp=200", o_time); end
    c0 = commit_cnt;
    send_frame(12'd33, 12'h700, 64);
    pulse_lat(lc);
    checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL next_commit got=%0d exp=1", commit_cnt - c0); end
    checks++; if (o_time !== 9'd33) begin failures++; $display("FAIL next_time got=%0d exp=33", o_time); end
  endtask

  task automatic test_reset_mid_frame();
    int w0, c0, e0, lc;
    c0 = commit_cnt; e0 = err_cnt;
    send_frame(12'd5, 12'h800, 20);
    send_word(12'hFFF, 5);
    @(negedge i_clk); i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_wen, o_waddr, o_wdata, o_time, o_commit, o_err} !== '0) begin
      failures++; $display("FAIL async_reset_outputs got=%h exp=0", {o_wen, o_waddr, o_wdata, o_time, o_commit, o_err});
    end
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    checks++; if (commit_cnt - c0 !== 0 || err_cnt - e0 !== 0) begin
      failures++; $display("FAIL reset_no_pulse got=%0d/%0d exp=0/0", commit_cnt - c0, err_cnt - e0);
    end
    w0 = wen_cnt; c0 = commit_cnt;
    send_frame(12'd77, 12'h900, 64);
    pulse_lat(lc);
    checks++; if (addr_log[w0] !== 6'd63 || data_log[w0] !== 12'h900) begin
      failures++; $display("FAIL post_reset_first_write got=%0d:%h exp=63:900", addr_log[w0], data_log[w0]);
    end
    checks++; if (wen_cnt - w0 !== 64) begin failures++; $display("FAIL post_reset_wen got=%0d exp=64", wen_cnt - w0); end
    checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL post_reset_commit got=%0d exp=1", commit_cnt - c0); end
    checks++; if (o_time !== 9'd77) begin failures++; $display("FAIL post_reset_time got=%0d exp=77", o_time); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_clamp();
    test_short();
    test_overflow();
    test_lat_sclk_collide();
    test_reset_mid_frame();
    checks++; if (dbl_wen !== 0) begin failures++; $display("FAIL wen_back_to_back got=%0d exp=0", dbl_wen); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
